mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one shared backing-memory port between the pipeline's instruction-fetch requester (IF) and data-memory requester (MEM stage load/store). Registers each granted transaction, holds it stable until the memory acknowledges, then returns read data with a one-cycle ready pulse. Drives the pipeline-wide stall while any requester is waiting. A watchdog aborts transactions the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, maximum BUSY cycles without ack before abort; legal range 1..65535

Ports:
- clk_i  in  1  clock; all flops rise-edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request, held until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_ready_o  out  1  one-cycle completion pulse to IF
- if_rdata_o  out  DATA_W  fetched instruction, valid with if_ready_o
- dm_req_i  in  1  data request, held until dm_ready_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_ready_o  out  1  one-cycle completion pulse to MEM stage
- dm_rdata_o  out  DATA_W  load data, valid with dm_ready_o
- mem_req_o  out  1  request to backing memory
- mem_we_o  out  1  write enable to backing memory
- mem_addr_o  out  ADDR_W  address to backing memory
- mem_wdata_o  out  DATA_W  write data to backing memory
- mem_ack_i  in  1  memory completion, single cycle
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- stall_o  out  1  freeze PC and pipeline registers
- err_o  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Select a requester and latch addr/we/wdata into output registers.
  - Go to BUSY_I or BUSY_D; with no request, stay in IDLE.
  - A requester whose ready_o is high this cycle is ignored, since its req is still high.
- Default arbitration is fixed priority: dm beats if, because the MEM-stage instruction is older.
- BUSY_x:
  - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o are held constant.
  - The watchdog counts from 0.
- On mem_ack_i in BUSY_x:
  - Capture mem_rdata_i into x_rdata_o. For stores, x_rdata_o is 0.
  - Pulse x_ready_o next cycle; return to IDLE.
- Watchdog abort: the count reaches TIMEOUT_CYC without ack.
  - Set err_o; it clears only on reset.
  - Pulse x_ready_o with x_rdata_o = 0; return to IDLE.
- Ack and timeout in the same cycle: ack wins, err_o is not set.
- mem_ack_i in IDLE is ignored, including a stale ack after reset.
- Requester dropping req mid-transaction is a protocol violation; the transaction still completes and ready still pulses.
- stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o); combinational.
- mem_we_o is 0 whenever the state is BUSY_I.

## Timing
- Reset values, asynchronous and immediate: state IDLE, and every registered output 0. This covers mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ready_o, dm_ready_o, if_rdata_o, dm_rdata_o and err_o. Also last-grant = IF and watchdog = 0.
- Minimum latency is 2 cycles:
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: mem_req_o = 1, ack arrives.
  - Cycle 2: ready_o = 1.
- An N-cycle memory latency gives ready at cycle N+1.
- Back-to-back throughput is one transaction per 2 + memory-latency cycles. The IDLE cycle coincides with the ready pulse.
- Abort: ready pulses TIMEOUT_CYC+1 cycles after entering BUSY.
- Reset mid-BUSY: mem_req_o drops asynchronously and no ready pulse is issued.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - When both request in IDLE, grant the requester not granted last.
  - A single requester is always granted.
  - The last-grant register updates on each grant.
- MEM_ARB_RR_EN undefined: fixed dm-over-if priority; no last-grant register is built.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, BUSY_I, BUSY_D)
  - grant enum (GNT_IF, GNT_DM)
  - default ADDR_W/DATA_W constants
  - watchdog counter width constant (16)
- Sub-module mem_arb_watchdog contains the clear/enable counter with a terminal-count output, reset by rst_i. Everything else lives in the top.

## Test plan
- Single load: dm_req=1, we=0, addr=0x40; ack after 3 cycles with rdata=0xDEADBEEF. Expect dm_ready pulse at cycle 4 with dm_rdata=0xDEADBEEF, and stall_o high cycles 0–3.
- Conflict: if_req and dm_req both rise at cycle 0 with immediate acks. Fixed build: dm served first, then if. RR build with last-grant = DM: if served first.
- Store: dm_we=1, addr=0x80, wdata=0x12345678. Expect mem_we_o=1 and mem_wdata_o=0x12345678 held stable until ack; dm_rdata=0.
- Timeout: TIMEOUT_CYC=4, no ack. Expect if_ready pulse with rdata=0, err_o=1 and staying 1, state back to IDLE. A later normal fetch completes with err_o still 1.
- Ack coinciding with terminal count: err_o remains 0 and rdata is passed through.
- Reset in BUSY_D: rst_i pulse mid-transaction. Expect mem_req_o=0 immediately; an ack delivered next cycle produces no ready pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WDOG_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } grant_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Clear/enable cycle counter with a terminal-count flag, used to abort
// transactions the backing memory never acknowledges.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WDOG_W-1:0] LIMIT_W = WDOG_W'(LIMIT);

    logic [WDOG_W-1:0] count;

    // Saturates rather than wrapping so a missed clear can never fake a fresh count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WDOG_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between instruction fetch and the MEM stage.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dm has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ready_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    state_t state;
    grant_t grant;
    logic   if_elig;
    logic   dm_elig;
    logic   grant_valid;
    logic   wdog_tc;

    // A requester still holding req during its own ready pulse is already served.
    assign if_elig     = if_req_i & ~if_ready_o;
    assign dm_elig     = dm_req_i & ~dm_ready_o;
    assign grant_valid = if_elig | dm_elig;

    assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

`ifdef MEM_ARB_RR_EN
    grant_t last_grant;

    always_comb begin
        grant = GNT_IF;
        if (if_elig && dm_elig) begin
            grant = (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (dm_elig) begin
            grant = GNT_DM;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= GNT_IF;
        end else if ((state == IDLE) && grant_valid) begin
            last_grant <= grant;
        end
    end
`else
    // The MEM-stage instruction is older than the one being fetched.
    always_comb begin
        grant = GNT_IF;
        if (dm_elig) begin
            grant = GNT_DM;
        end
    end
`endif

    mem_arb_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (state == IDLE),
        .en    (state != IDLE),
        .tc    (wdog_tc)
    );

    // Ack is checked before the watchdog so a coincident ack is never reported as an error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ready_o  <= 1'b0;
            dm_ready_o  <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            if_ready_o <= 1'b0;
            dm_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_req_o <= 1'b1;
                        if (grant == GNT_DM) begin
                            state       <= BUSY_D;
                            mem_we_o    <= dm_we_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                        end else begin
                            state       <= BUSY_I;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        if_ready_o <= 1'b1;
                        if_rdata_o <= mem_rdata_i;
                    end else if (wdog_tc) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        if_ready_o <= 1'b1;
                        if_rdata_o <= '0;
                        err_o      <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        dm_ready_o <= 1'b1;
                        dm_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                    end else if (wdog_tc) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        dm_ready_o <= 1'b1;
                        dm_rdata_o <= '0;
                        err_o      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for watchdog, ack-at-terminal-count and reset-during-transaction.
module tb_mem_port_arbiter;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_ready_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_ready_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        ack;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_ifrdy;
        logic [31:0] e_ifrdata;
        logic        e_dmrdy;
        logic [31:0] e_dmrdata;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ready_o  (if_ready_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_ready_o  (dm_ready_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
        input logic ak, input logic [31:0] rd,
        input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd,
        input logic irr, input logic [31:0] ird,
        input logic drr, input logic [31:0] drd,
        input logic st);
        vec_t r;
        r.if_req = ir;  r.if_addr = ia;
        r.dm_req = dr;  r.dm_we = dw;  r.dm_addr = da;  r.dm_wdata = dwd;
        r.ack = ak;     r.mrdata = rd;
        r.e_mreq = mr;  r.e_mwe = mw;  r.e_maddr = ma;  r.e_mwdata = mwd;
        r.e_ifrdy = irr; r.e_ifrdata = ird;
        r.e_dmrdy = drr; r.e_dmrdata = drd;
        r.e_stall = st;
        return r;
    endfunction

    function automatic vec_t idleRow();
        return mk(F, 32'h0, F, F, 32'h0, 32'h0, F, 32'h0,
                  F, F, 32'h0, 32'h0, F, 32'h0, F, 32'h0, F);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        nextCycle();
        if_req_i    = v.if_req;
        if_addr_i   = v.if_addr;
        dm_req_i    = v.dm_req;
        dm_we_i     = v.dm_we;
        dm_addr_i   = v.dm_addr;
        dm_wdata_i  = v.dm_wdata;
        mem_ack_i   = v.ack;
        mem_rdata_i = v.mrdata;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("row%0d.mem_req", idx), 32'(mem_req_o), 32'(v.e_mreq));
        checkVal($sformatf("row%0d.stall", idx), 32'(stall_o), 32'(v.e_stall));
        checkVal($sformatf("row%0d.if_ready", idx), 32'(if_ready_o), 32'(v.e_ifrdy));
        checkVal($sformatf("row%0d.dm_ready", idx), 32'(dm_ready_o), 32'(v.e_dmrdy));
        checkVal($sformatf("row%0d.err", idx), 32'(err_o), 32'(1'b0));
        if (v.e_mreq) begin
            checkVal($sformatf("row%0d.mem_addr", idx), mem_addr_o, v.e_maddr);
            checkVal($sformatf("row%0d.mem_we", idx), 32'(mem_we_o), 32'(v.e_mwe));
        end
        if (v.e_mreq && v.e_mwe)
            checkVal($sformatf("row%0d.mem_wdata", idx), mem_wdata_o, v.e_mwdata);
        if (v.e_ifrdy)
            checkVal($sformatf("row%0d.if_rdata", idx), if_rdata_o, v.e_ifrdata);
        if (v.e_dmrdy)
            checkVal($sformatf("row%0d.dm_rdata", idx), dm_rdata_o, v.e_dmrdata);
    endtask

    task automatic buildTable();
        // Conflict right after reset: dm first in both builds (last grant resets to IF).
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, T, 32'h22, T, F, 32'h200, 32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, F, 32'h0,  T, 32'h22, T));
        vecs.push_back(mk(T, 32'h100, F, F, 32'h0,   32'h0, T, 32'h11, T, F, 32'h100, 32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(T, 32'h100, F, F, 32'h0,   32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, T, 32'h11, F, 32'h0,  F));
        vecs.push_back(idleRow());
        // Single load, memory acks three cycles after the request is sampled.
        vecs.push_back(mk(F, 32'h0, T, F, 32'h40, 32'h0, F, 32'h0,        F, F, 32'h0,  32'h0, F, 32'h0, F, 32'h0,        T));
        vecs.push_back(mk(F, 32'h0, T, F, 32'h40, 32'h0, F, 32'h0,        T, F, 32'h40, 32'h0, F, 32'h0, F, 32'h0,        T));
        vecs.push_back(mk(F, 32'h0, T, F, 32'h40, 32'h0, F, 32'h0,        T, F, 32'h40, 32'h0, F, 32'h0, F, 32'h0,        T));
        vecs.push_back(mk(F, 32'h0, T, F, 32'h40, 32'h0, T, 32'hDEADBEEF, T, F, 32'h40, 32'h0, F, 32'h0, F, 32'h0,        T));
        vecs.push_back(mk(F, 32'h0, T, F, 32'h40, 32'h0, F, 32'h0,        F, F, 32'h0,  32'h0, F, 32'h0, T, 32'hDEADBEEF, F));
        vecs.push_back(idleRow());
        // Conflict with last grant = DM.
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, F, 32'h0,  F, 32'h0,  T));
`ifdef MEM_ARB_RR_EN
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, T, 32'h33, T, F, 32'h100, 32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, T, 32'h33, F, 32'h0,  T));
        vecs.push_back(mk(F, 32'h0,   T, F, 32'h200, 32'h0, T, 32'h44, T, F, 32'h200, 32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(F, 32'h0,   T, F, 32'h200, 32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, F, 32'h0,  T, 32'h44, F));
`else
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, T, 32'h33, T, F, 32'h200, 32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(T, 32'h100, T, F, 32'h200, 32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, F, 32'h0,  T, 32'h33, T));
        vecs.push_back(mk(T, 32'h100, F, F, 32'h0,   32'h0, T, 32'h44, T, F, 32'h100, 32'h0, F, 32'h0,  F, 32'h0,  T));
        vecs.push_back(mk(T, 32'h100, F, F, 32'h0,   32'h0, F, 32'h0,  F, F, 32'h0,   32'h0, T, 32'h44, F, 32'h0,  F));
`endif
        vecs.push_back(idleRow());
        // Store: write data held until ack, read data returned as zero.
        vecs.push_back(mk(F, 32'h0, T, T, 32'h80, 32'h12345678, F, 32'h0,        F, F, 32'h0,  32'h0,        F, 32'h0, F, 32'h0, T));
        vecs.push_back(mk(F, 32'h0, T, T, 32'h80, 32'h12345678, F, 32'h0,        T, T, 32'h80, 32'h12345678, F, 32'h0, F, 32'h0, T));
        vecs.push_back(mk(F, 32'h0, T, T, 32'h80, 32'h12345678, F, 32'h0,        T, T, 32'h80, 32'h12345678, F, 32'h0, F, 32'h0, T));
        vecs.push_back(mk(F, 32'h0, T, T, 32'h80, 32'h12345678, T, 32'hAAAA5555, T, T, 32'h80, 32'h12345678, F, 32'h0, F, 32'h0, T));
        vecs.push_back(mk(F, 32'h0, T, T, 32'h80, 32'h12345678, F, 32'h0,        F, F, 32'h0,  32'h0,        F, 32'h0, T, 32'h0, F));
        vecs.push_back(idleRow());
    endtask

    task automatic driveIdle();
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got 0 expected 1 (bench did not finish)");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        buildTable();

        // Reset state, with a stale ack present while reset is held.
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checkVal("rst.mem_req", 32'(mem_req_o), 32'h0);
        checkVal("rst.mem_we", 32'(mem_we_o), 32'h0);
        checkVal("rst.mem_addr", mem_addr_o, 32'h0);
        checkVal("rst.mem_wdata", mem_wdata_o, 32'h0);
        checkVal("rst.if_ready", 32'(if_ready_o), 32'h0);
        checkVal("rst.dm_ready", 32'(dm_ready_o), 32'h0);
        checkVal("rst.if_rdata", if_rdata_o, 32'h0);
        checkVal("rst.dm_rdata", dm_rdata_o, 32'h0);
        checkVal("rst.err", 32'(err_o), 32'h0);
        nextCycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        nextCycle();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        checkVal("stale_ack.if_ready", 32'(if_ready_o), 32'h0);
        checkVal("stale_ack.dm_ready", 32'(dm_ready_o), 32'h0);
        checkVal("stale_ack.mem_req", 32'(mem_req_o), 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk_i);
            checkOutput(vecs[i], i);
        end

        // Ack arriving exactly on the watchdog terminal count: ack wins.
        nextCycle();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500;
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            @(negedge clk_i);
            checkVal($sformatf("tc_ack.c%0d.mem_req", k), 32'(mem_req_o), 32'h1);
        end
        nextCycle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
        @(negedge clk_i);
        checkVal("tc_ack.c5.mem_req", 32'(mem_req_o), 32'h1);
        nextCycle();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        @(negedge clk_i);
        checkVal("tc_ack.dm_ready", 32'(dm_ready_o), 32'h1);
        checkVal("tc_ack.dm_rdata", dm_rdata_o, 32'h77);
        checkVal("tc_ack.err", 32'(err_o), 32'h0);
        nextCycle();
        driveIdle();
        @(negedge clk_i);
        checkVal("tc_ack.ready_drop", 32'(dm_ready_o), 32'h0);

        // Watchdog abort on a fetch that is never acknowledged.
        nextCycle();
        if_req_i = 1'b1; if_addr_i = 32'h300;
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            @(negedge clk_i);
            checkVal($sformatf("wdog.c%0d.mem_req", k), 32'(mem_req_o), 32'h1);
            checkVal($sformatf("wdog.c%0d.if_ready", k), 32'(if_ready_o), 32'h0);
            checkVal($sformatf("wdog.c%0d.err", k), 32'(err_o), 32'h0);
            checkVal($sformatf("wdog.c%0d.stall", k), 32'(stall_o), 32'h1);
        end
        nextCycle();
        @(negedge clk_i);
        checkVal("wdog.if_ready", 32'(if_ready_o), 32'h1);
        checkVal("wdog.if_rdata", if_rdata_o, 32'h0);
        checkVal("wdog.err", 32'(err_o), 32'h1);
        checkVal("wdog.mem_req", 32'(mem_req_o), 32'h0);
        nextCycle();
        driveIdle();
        @(negedge clk_i);
        checkVal("wdog.err_sticky", 32'(err_o), 32'h1);
        checkVal("wdog.ready_drop", 32'(if_ready_o), 32'h0);

        // A normal fetch afterwards still completes; err stays set.
        nextCycle();
        if_req_i = 1'b1; if_addr_i = 32'h304;
        nextCycle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55;
        @(negedge clk_i);
        checkVal("after_wdog.mem_req", 32'(mem_req_o), 32'h1);
        checkVal("after_wdog.mem_addr", mem_addr_o, 32'h304);
        checkVal("after_wdog.mem_we", 32'(mem_we_o), 32'h0);
        nextCycle();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        @(negedge clk_i);
        checkVal("after_wdog.if_ready", 32'(if_ready_o), 32'h1);
        checkVal("after_wdog.if_rdata", if_rdata_o, 32'h55);
        checkVal("after_wdog.err", 32'(err_o), 32'h1);
        nextCycle();
        driveIdle();

        // Reset during a data transaction: request drops at once, late ack is ignored.
        nextCycle();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h600;
        nextCycle();
        @(negedge clk_i);
        checkVal("rst_busy.mem_req_before", 32'(mem_req_o), 32'h1);
        rst_i = 1'b1;
        dm_req_i = 1'b0;
        #1;
        checkVal("rst_busy.mem_req_async", 32'(mem_req_o), 32'h0);
        checkVal("rst_busy.err_cleared", 32'(err_o), 32'h0);
        nextCycle();
        rst_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
        @(negedge clk_i);
        checkVal("rst_busy.c1.dm_ready", 32'(dm_ready_o), 32'h0);
        checkVal("rst_busy.c1.mem_req", 32'(mem_req_o), 32'h0);
        nextCycle();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        @(negedge clk_i);
        checkVal("rst_busy.c2.dm_ready", 32'(dm_ready_o), 32'h0);
        checkVal("rst_busy.c2.mem_req", 32'(mem_req_o), 32'h0);
        checkVal("rst_busy.c2.dm_rdata", dm_rdata_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
